// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: fetch handshake and instruction in, register-file addresses out and data in,
// decoded ID/EX op out with its handshake, plus the stall counter.
interface id_stage_pipe_if #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3+3*ADDR_W:0]   instr;
    logic                  hazard;
    logic                  flush;
    logic                  flagZ;
    logic [ADDR_W-1:0]     src1;
    logic [ADDR_W-1:0]     src2;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            exe_cmd;
    logic [DATA_W-1:0]     val1;
    logic [DATA_W-1:0]     val2;
    logic [ADDR_W-1:0]     dest;
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  is_imm;
    logic                  br_taken;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output in_valid, instr, hazard, flush, flagZ, reg1, reg2, out_ready,
        input  in_ready, src1, src2, out_valid, exe_cmd, val1, val2, dest,
               wb_en, mem_r_en, mem_w_en, is_imm, br_taken, stall_cnt
    );

    modport slave (
        input  in_valid, instr, hazard, flush, flagZ, reg1, reg2, out_ready,
        output in_ready, src1, src2, out_valid, exe_cmd, val1, val2, dest,
               wb_en, mem_r_en, mem_w_en, is_imm, br_taken, stall_cnt
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: decodes one instruction per cycle into an ID/EX register with bubbles, flush, stall count.
// Latency 1 cycle, throughput 1 op/cycle; optional one-entry skid buffer when ID_SKID_BUF_EN is defined.
// Backpressure: out_ready=0 holds ID/EX stable and drops in_ready (skid build accepts one extra op first).
module id_stage_pipe #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);
    localparam int IW = 4 + 3 * ADDR_W;

    typedef struct packed {
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [ADDR_W-1:0] dest;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              is_imm;
        logic              br_taken;
    } idex_t;

    logic [3:0]        op;
    logic [ADDR_W-1:0] rd, rs1, rs2;
    logic              is_br, is_imm_op, uses_rd;
    idex_t             dec, idex;
    logic              out_valid_q, ready_en, load, accept;
    logic [CNT_W-1:0]  stall_q;

    assign op  = bus.instr[IW-1 -: 4];
    assign rd  = bus.instr[3*ADDR_W-1 -: ADDR_W];
    assign rs1 = bus.instr[2*ADDR_W-1 -: ADDR_W];
    assign rs2 = bus.instr[ADDR_W-1:0];

    assign is_br     = (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    assign is_imm_op = (op == 4'h6) || (op == 4'h7) || (op == 4'h8);
    // CMP and STR read rd as their first source and rs1 as their second.
    assign uses_rd   = (op == 4'h9) || (op == 4'hB);

    assign bus.src1 = (is_imm_op || is_br) ? '1 : (uses_rd ? rd : rs1);
    assign bus.src2 = ((op == 4'hA) || is_imm_op || is_br || (op == 4'h5)) ? '1 : (uses_rd ? rs1 : rs2);

    always_comb begin
        dec          = '0;
        dec.exe_cmd  = op;
        dec.dest     = rd;
        dec.wb_en    = ((op >= 4'h1) && (op <= 4'h8)) || (op == 4'hA);
        dec.mem_r_en = (op == 4'hA);
        dec.mem_w_en = (op == 4'hB);
        dec.is_imm   = is_imm_op;
        dec.br_taken = (op == 4'hC) || ((op == 4'hD) && bus.flagZ) || ((op == 4'hE) && !bus.flagZ);
        dec.val1     = (is_br || is_imm_op) ? '0 : bus.reg1;
        if ((op == 4'h5) || (op == 4'hA) || (op == 4'hB))
            dec.val2 = '0;
        else if (is_imm_op)
            dec.val2 = DATA_W'($signed(bus.instr[2*ADDR_W-1:0]));
        else if (is_br)
            dec.val2 = DATA_W'($signed(bus.instr[3*ADDR_W-1:0]));
        else
            dec.val2 = bus.reg2;
    end

    assign load   = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;

    // Keeps in_ready low while reset is asserted and for the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ready_en <= 1'b0;
        else      ready_en <= 1'b1;
    end

`ifdef ID_SKID_BUF_EN
    logic  skid_full;
    idex_t skid;

    assign bus.in_ready = ready_en && !skid_full && !bus.hazard && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            idex        <= '0;
            skid_full   <= 1'b0;
            skid        <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            idex        <= '0;
            skid_full   <= 1'b0;
        end else if (load) begin
            // A parked op always drains first, even under hazard.
            if (skid_full) begin
                idex        <= skid;
                out_valid_q <= 1'b1;
                skid_full   <= 1'b0;
            end else if (accept) begin
                idex        <= dec;
                out_valid_q <= 1'b1;
            end else if (bus.hazard) begin
                idex        <= '0;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid      <= dec;
            skid_full <= 1'b1;
        end
    end
`else
    assign bus.in_ready = ready_en && load && !bus.hazard && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            idex        <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            idex        <= '0;
        end else if (load) begin
            if (accept) begin
                idex        <= dec;
                out_valid_q <= 1'b1;
            end else if (bus.hazard) begin
                idex        <= '0;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else if (bus.in_valid && !bus.in_ready && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
    end

    assign bus.out_valid = out_valid_q;
    assign bus.exe_cmd   = idex.exe_cmd;
    assign bus.val1      = idex.val1;
    assign bus.val2      = idex.val2;
    assign bus.dest      = idex.dest;
    assign bus.wb_en     = idex.wb_en;
    assign bus.mem_r_en  = idex.mem_r_en;
    assign bus.mem_w_en  = idex.mem_w_en;
    assign bus.is_imm    = idex.is_imm;
    assign bus.br_taken  = idex.br_taken;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: scoreboard of expected ID/EX ops plus per-scenario direct checks.
module tb_id_stage_pipe;
    localparam int DATA_W = 24;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus();
    id_stage_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  exe_cmd;
        logic [23:0] val1;
        logic [23:0] val2;
        logic [3:0]  dest;
        logic        wb;
        logic        mr;
        logic        mw;
        logic        imm;
        logic        br;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [23:0] rfval(input logic [3:0] a);
        return {4'hA, a, 8'h5C, ~a, a};
    endfunction

    // Register file answers the stage's combinational read addresses.
    assign bus.reg1 = rfval(bus.src1);
    assign bus.reg2 = rfval(bus.src2);
    assign cur = {bus.exe_cmd, bus.val1, bus.val2, bus.dest, bus.wb_en, bus.mem_r_en,
                  bus.mem_w_en, bus.is_imm, bus.br_taken};

    function automatic exp_t model(input logic [15:0] ins, input logic fz);
        exp_t e;
        logic [3:0] op, rd, rs1, rs2, s1, s2;
        logic br, im;
        op  = ins[15:12];
        rd  = ins[11:8];
        rs1 = ins[7:4];
        rs2 = ins[3:0];
        br  = (op >= 4'hC) && (op <= 4'hE);
        im  = (op >= 4'h6) && (op <= 4'h8);
        if (im || br) s1 = 4'hF;
        else if (op == 4'h9 || op == 4'hB) s1 = rd;
        else s1 = rs1;
        if (op == 4'hA || im || br || op == 4'h5) s2 = 4'hF;
        else if (op == 4'h9 || op == 4'hB) s2 = rs1;
        else s2 = rs2;
        e.exe_cmd = op;
        e.dest    = rd;
        e.wb      = (op >= 4'h1 && op <= 4'h8) || op == 4'hA;
        e.mr      = (op == 4'hA);
        e.mw      = (op == 4'hB);
        e.imm     = im;
        e.br      = (op == 4'hC) || (op == 4'hD && fz) || (op == 4'hE && !fz);
        e.val1    = (br || im) ? 24'h0 : rfval(s1);
        if (op == 4'h5 || op == 4'hA || op == 4'hB) e.val2 = 24'h0;
        else if (im) e.val2 = {{16{ins[7]}}, ins[7:0]};
        else if (br) e.val2 = {{12{ins[11]}}, ins[11:0]};
        else e.val2 = rfval(s2);
        return e;
    endfunction

    // Scoreboard: every completed output handshake must match the oldest expected op.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_output got=%h required=none", cur);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL sb_output got=%h required=%h", cur, e);
                end
            end
        end
    end

    task automatic send(input logic [15:0] ins, input logic fz);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.flagZ    = fz;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                sb.push_back(model(ins, fz));
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout instr=%h in_ready=%b required=1", ins, bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 0; bus.instr = '0; bus.hazard = 0; bus.flush = 0;
        bus.flagZ = 0; bus.out_ready = 1;
        #1 rst = 1'b0;
        #2;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b required=0", bus.in_ready); end
        checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d required=0", bus.stall_cnt); end
        checks++; if (cur !== '0) begin errors++; $display("FAIL rst_outputs got=%h required=0", cur); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b required=1", bus.in_ready); end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL drain_%s left=%0d required=0", name, sb.size()); end
    endtask

    task automatic test_imm();
        bus.instr = 16'h63FF;
        #1;
        checks++; if (bus.src1 !== 4'hF || bus.src2 !== 4'hF) begin errors++; $display("FAIL imm_src got=%h/%h required=f/f", bus.src1, bus.src2); end
        send(16'h63FF, 1'b0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL imm_latency out_valid=%b required=1", bus.out_valid); end
        checks++; if (bus.is_imm !== 1'b1 || bus.wb_en !== 1'b1) begin errors++; $display("FAIL imm_ctrl is_imm=%b wb_en=%b required=1/1", bus.is_imm, bus.wb_en); end
        checks++; if (bus.val1 !== 24'h0 || bus.val2 !== 24'hFFFFFF) begin errors++; $display("FAIL imm_vals got=%h/%h required=000000/ffffff", bus.val1, bus.val2); end
        drain("imm");
    endtask

    task automatic test_branch();
        send(16'hD800, 1'b1);
        checks++; if (bus.br_taken !== 1'b1 || bus.val2 !== 24'hFFF800) begin errors++; $display("FAIL beq_taken br=%b val2=%h required=1/fff800", bus.br_taken, bus.val2); end
        send(16'hD800, 1'b0);
        checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL beq_not_taken br=%b required=0", bus.br_taken); end
        send(16'hE800, 1'b1);
        checks++; if (bus.br_taken !== 1'b0) begin errors++; $display("FAIL bne_not_taken br=%b required=0", bus.br_taken); end
        send(16'hE800, 1'b0);
        checks++; if (bus.br_taken !== 1'b1) begin errors++; $display("FAIL bne_taken br=%b required=1", bus.br_taken); end
        send(16'hC123, 1'b0);
        send(16'hF456, 1'b1);
        drain("branch");
    endtask

    task automatic test_str();
        bus.instr = 16'hB357;
        #1;
        checks++; if (bus.src1 !== 4'h3 || bus.src2 !== 4'h5) begin errors++; $display("FAIL str_src got=%h/%h required=3/5", bus.src1, bus.src2); end
        send(16'hB357, 1'b0);
        checks++; if (bus.mem_w_en !== 1'b1 || bus.val2 !== 24'h0 || bus.val1 !== rfval(4'h3)) begin
            errors++; $display("FAIL str_out mw=%b val1=%h val2=%h required=1/%h/000000", bus.mem_w_en, bus.val1, bus.val2, rfval(4'h3));
        end
        drain("str");
    endtask

    task automatic test_back_to_back();
        time t0;
        t0 = $time;
        for (int op = 0; op < 16; op++) send({4'(op), 12'($urandom)}, 1'($urandom));
        checks++; if ($time - t0 != 160) begin errors++; $display("FAIL b2b_throughput elapsed=%0t required=160", $time - t0); end
        drain("b2b");
    endtask

    task automatic test_hazard();
        bus.out_ready = 1; bus.in_valid = 1; bus.instr = 16'h1123; bus.flagZ = 0; bus.hazard = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hazard_in_ready got=%b required=0", bus.in_ready); end
            sb.push_back('0);
            @(posedge clk);
            #1;
        end
        bus.hazard = 0;
        send(16'h1123, 1'b0);
        checks++; if (bus.stall_cnt !== 16'd2) begin errors++; $display("FAIL hazard_stall_cnt got=%0d required=2", bus.stall_cnt); end
        drain("hazard");
    endtask

    task automatic test_hold();
        exp_t ea;
        bit   acc;
        acc = 0;
        ea  = model(16'h2A4B, 1'b0);
        bus.out_ready = 1;
        send(16'h2A4B, 1'b0);
        bus.out_ready = 0;
        bus.in_valid = 1; bus.instr = 16'h9C12; bus.flagZ = 1;
        for (int i = 0; i < 3; i++) begin
            bus.hazard = (i == 1);
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1 || cur !== ea) begin errors++; $display("FAIL hold_stable cyc=%0d got=%b/%h required=1/%h", i, bus.out_valid, cur, ea); end
`ifndef ID_SKID_BUF_EN
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b required=0", i, bus.in_ready); end
`endif
            if (!acc && bus.in_valid && bus.in_ready) begin sb.push_back(model(16'h9C12, 1'b1)); acc = 1; end
            @(posedge clk);
            #1;
            if (acc) bus.in_valid = 0;
        end
        bus.hazard = 0;
        bus.out_ready = 1;
        if (!acc) send(16'h9C12, 1'b1);
        send(16'h7301, 1'b0);
        drain("hold");
    endtask

    task automatic test_backpressure();
        bit stop;
        stop = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) send(16'($urandom), 1'($urandom));
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.out_ready = 1;
        drain("backpressure");
    endtask

    task automatic test_flush();
        bus.out_ready = 0;
        send(16'h2456, 1'b0);
        bus.in_valid = 1; bus.instr = 16'h3789; bus.flush = 1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b required=0", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.flush = 0; bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b0 || cur !== '0) begin errors++; $display("FAIL flush_clear got=%b/%h required=0/0", bus.out_valid, cur); end
        sb.delete();
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_emit got=%b required=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 0;
        send(16'h4ABC, 1'b1);
        bus.in_valid = 1; bus.instr = 16'h1DEF;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || cur !== '0) begin errors++; $display("FAIL midrst_outputs got=%b/%h required=0/0", bus.out_valid, cur); end
        checks++; if (bus.stall_cnt !== 16'd0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL midrst_cnt_rdy got=%0d/%b required=0/0", bus.stall_cnt, bus.in_ready); end
        sb.delete();
        bus.in_valid = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        bus.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_dropped got=%b required=0", bus.out_valid); end
        send(16'h7123, 1'b0);
        drain("midrst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_imm();
        test_branch();
        test_str();
        test_back_to_back();
        test_hazard();
        test_hold();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
